// File: rtl/bubble_dbg_pkg.sv
// Shared types and constants for the bubble page UART debug streamer.
package bubble_dbg_pkg;

   localparam int unsigned BUF_BITS   = 8192;
   localparam int unsigned BUF_BYTES  = 1024;
   localparam int unsigned ADDR_W     = 13;
   localparam int unsigned BYTE_IDX_W = 10;
   localparam int unsigned PAGE_W     = 12;

   localparam logic [7:0] SYNC_BOOT = 8'hA5;
   localparam logic [7:0] SYNC_USER = 8'hC3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_PGHI,
      ST_PGLO,
      ST_DATA,
      ST_CSUM
   } state_e;

   // Request captured when a packet is accepted.
   typedef struct packed {
      logic              boot;
      logic [PAGE_W-1:0] relpage;
   } pkt_hdr_t;

   function automatic logic [7:0] sync_byte(input logic boot);
      return boot ? SYNC_BOOT : SYNC_USER;
   endfunction

endpackage

// File: rtl/bubble_page_uart_streamer_uart_tx_byte.sv
// 8N1 byte serializer: START loads a byte, DONE pulses during the last stop-bit cycle.
module uart_tx_byte #(
   parameter int unsigned CLKS_PER_BIT = 48
) (
   input  logic       MCLK,
   input  logic       nRESET,
   input  logic       START,
   input  logic [7:0] DATA,
   output logic       TXD,
   output logic       DONE
);

   localparam int unsigned CNT_W   = 10;
   localparam int unsigned BIT_W   = 4;
   localparam int unsigned FRAME_W = 10;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
   localparam logic [BIT_W-1:0] STOP_IDX = BIT_W'(FRAME_W - 1);

   logic               active_q, active_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BIT_W-1:0]   bit_idx_q, bit_idx_d;
   logic [FRAME_W-1:0] shreg_q, shreg_d;
   logic               txd_q, txd_d;
   logic               done_q, done_d;

   always_comb begin : ser_next
      active_d  = active_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      txd_d     = txd_q;
      done_d    = 1'b0;
      if (!active_q) begin
         if (START) begin
            active_d  = 1'b1;
            cnt_d     = '0;
            bit_idx_d = '0;
            shreg_d   = {1'b1, DATA, 1'b0};
            txd_d     = 1'b0;
         end
      end else begin
         if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (bit_idx_q == STOP_IDX) begin
               active_d = 1'b0;
               txd_d    = 1'b1;
            end else begin
               bit_idx_d = bit_idx_q + BIT_W'(1);
               shreg_d   = {1'b1, shreg_q[FRAME_W-1:1]};
               txd_d     = shreg_q[1];
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         // Registered so that it is high exactly in the final stop-bit cycle.
         if ((bit_idx_q == STOP_IDX) && (cnt_q == CNT_PRE)) done_d = 1'b1;
      end
   end

   always_ff @(posedge MCLK or negedge nRESET) begin : ser_regs
      if (!nRESET) begin
         active_q  <= 1'b0;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '1;
         txd_q     <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         active_q  <= active_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
         txd_q     <= txd_d;
         done_q    <= done_d;
      end
   end

   assign TXD  = txd_q;
   assign DONE = done_q;

endmodule

// File: rtl/bubble_page_uart_streamer.sv
// Captures the SPI-written page bitstream and streams it to a host as a framed 8N1 packet.
module bubble_page_uart_streamer
   import bubble_dbg_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 48,
   parameter int unsigned BOOT_BYTES   = 1024,
   parameter int unsigned USER_BYTES   = 64
) (
   input  logic              MCLK,
   input  logic              nRESET,
   input  logic              nFIFOBUFWRCLKEN,
   input  logic [ADDR_W-1:0] FIFOBUFWRADDR,
   input  logic              FIFOBUFWRDATA,
   input  logic              nFIFOSENDBOOT,
   input  logic              nFIFOSENDUSER,
   input  logic [PAGE_W-1:0] FIFORELPAGE,
   output logic              TXD,
   output logic              BUSY,
   output logic              OVERRUN
);

   logic                  boot_s1_q, boot_s2_q, user_s1_q, user_s2_q;
   state_e                state_q, state_d;
   logic                  busy_q, busy_d;
   logic                  ovr_q, ovr_d;
   pkt_hdr_t              hdr_q, hdr_d;
   logic [BYTE_IDX_W-1:0] idx_q, idx_d;
   logic [7:0]            csum_q, csum_d;
   logic                  fetch_q, fetch_d;
   logic                  start_q, start_d;
   logic [7:0]            rd_data_q;
   logic [7:0]            mem_q [BUF_BYTES];

   logic                  boot_edge_c, user_edge_c, req_c, accept_c;
   logic                  tx_start_c, tx_done_c;
   logic [7:0]            tx_data_c;
   logic [BYTE_IDX_W-1:0] last_idx_c;

   assign boot_edge_c = boot_s2_q & ~boot_s1_q;
   assign user_edge_c = user_s2_q & ~user_s1_q;
   assign req_c       = boot_edge_c | user_edge_c;
   assign accept_c    = req_c & ~busy_q;
   assign tx_start_c  = accept_c | start_q;
   assign last_idx_c  = hdr_q.boot ? BYTE_IDX_W'(BOOT_BYTES - 1) : BYTE_IDX_W'(USER_BYTES - 1);

   // Byte handed to the serializer; SYNC goes out straight from the accepting edge.
   always_comb begin : tx_mux
      tx_data_c = 8'h00;
      if (accept_c) begin
         tx_data_c = sync_byte(boot_edge_c);
      end else begin
         unique case (state_q)
            ST_PGHI: tx_data_c = {4'h0, hdr_q.relpage[11:8]};
            ST_PGLO: tx_data_c = hdr_q.relpage[7:0];
            ST_DATA: tx_data_c = rd_data_q;
            ST_CSUM: tx_data_c = csum_q;
            default: tx_data_c = 8'h00;
         endcase
      end
   end

   // Each DONE opens a fetch cycle, then START: the two idle-high gap cycles.
   always_comb begin : fsm_next
      state_d = state_q;
      busy_d  = busy_q;
      ovr_d   = ovr_q;
      hdr_d   = hdr_q;
      idx_d   = idx_q;
      csum_d  = csum_q;
      fetch_d = 1'b0;
      start_d = fetch_q;
      if (!nFIFOBUFWRCLKEN && busy_q) ovr_d = 1'b1;
      if (req_c && busy_q) ovr_d = 1'b1;
      if (accept_c) begin
         state_d      = ST_SYNC;
         busy_d       = 1'b1;
         hdr_d.boot   = boot_edge_c;
         hdr_d.relpage = FIFORELPAGE;
         idx_d        = '0;
         csum_d       = '0;
      end
      if (start_q && ((state_q == ST_PGHI) || (state_q == ST_PGLO) || (state_q == ST_DATA)))
         csum_d = csum_q + tx_data_c;
      if (tx_done_c) begin
         fetch_d = 1'b1;
         unique case (state_q)
            ST_SYNC: state_d = ST_PGHI;
            ST_PGHI: state_d = ST_PGLO;
            ST_PGLO: begin
               state_d = ST_DATA;
               idx_d   = '0;
            end
            ST_DATA: begin
               if (idx_q == last_idx_c) state_d = ST_CSUM;
               else                     idx_d   = idx_q + BYTE_IDX_W'(1);
            end
            default: begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               fetch_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge MCLK or negedge nRESET) begin : ctl_regs
      if (!nRESET) begin
         boot_s1_q <= 1'b1;
         boot_s2_q <= 1'b1;
         user_s1_q <= 1'b1;
         user_s2_q <= 1'b1;
         state_q   <= ST_IDLE;
         busy_q    <= 1'b0;
         ovr_q     <= 1'b0;
         hdr_q     <= '0;
         idx_q     <= '0;
         csum_q    <= '0;
         fetch_q   <= 1'b0;
         start_q   <= 1'b0;
      end else begin
         boot_s1_q <= nFIFOSENDBOOT;
         boot_s2_q <= boot_s1_q;
         user_s1_q <= nFIFOSENDUSER;
         user_s2_q <= user_s1_q;
         state_q   <= state_d;
         busy_q    <= busy_d;
         ovr_q     <= ovr_d;
         hdr_q     <= hdr_d;
         idx_q     <= idx_d;
         csum_q    <= csum_d;
         fetch_q   <= fetch_d;
         start_q   <= start_d;
      end
   end

   // Bit-writable page buffer with a registered byte read; contents survive reset.
   always_ff @(posedge MCLK) begin : buf_ram
      if (!nFIFOBUFWRCLKEN && !busy_q)
         mem_q[FIFOBUFWRADDR[ADDR_W-1:3]][FIFOBUFWRADDR[2:0]] <= FIFOBUFWRDATA;
      rd_data_q <= mem_q[idx_q];
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx (
      .MCLK  (MCLK),
      .nRESET(nRESET),
      .START (tx_start_c),
      .DATA  (tx_data_c),
      .TXD   (TXD),
      .DONE  (tx_done_c)
   );

   assign BUSY    = busy_q;
   assign OVERRUN = ovr_q;

endmodule

// File: tb/tb_bubble_page_uart_streamer.sv
// Randomized scoreboard bench: a UART monitor decodes TXD and compares each frame to a packet model.
`timescale 1ns/1ps
module tb_bubble_page_uart_streamer;

   localparam int unsigned CPB    = 4;
   localparam int unsigned BOOT_N = 1024;
   localparam int unsigned USER_N = 2;
   localparam int unsigned NBITS  = 8192;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        nwr = 1'b1;
   logic [12:0] wr_addr = '0;
   logic        wr_data = 1'b0;
   logic        nboot = 1'b1;
   logic        nuser = 1'b1;
   logic [11:0] relpage = '0;
   logic        txd, busy, overrun;

   int          cyc = 0;
   int          n_chk = 0;
   int          n_pass = 0;
   bit          mon_en = 1'b0;
   int          last_end = 0;
   bit          mem_m [NBITS];

   typedef struct {
      logic [7:0] data;
      bit         first;
   } exp_t;
   exp_t exp_q[$];

   bubble_page_uart_streamer #(
      .CLKS_PER_BIT(CPB),
      .BOOT_BYTES  (BOOT_N),
      .USER_BYTES  (USER_N)
   ) dut (
      .MCLK           (clk),
      .nRESET         (rst_n),
      .nFIFOBUFWRCLKEN(nwr),
      .FIFOBUFWRADDR  (wr_addr),
      .FIFOBUFWRDATA  (wr_data),
      .nFIFOSENDBOOT  (nboot),
      .nFIFOSENDUSER  (nuser),
      .FIFORELPAGE    (relpage),
      .TXD            (txd),
      .BUSY           (busy),
      .OVERRUN        (overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input bit ok, input string name, input longint act, input longint want);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
   endfunction

   // Packet model: header, page bytes LSB-first from the bit buffer, modulo-256 checksum.
   function automatic void push_packet(input bit boot, input logic [11:0] page);
      int         nbytes;
      int         sum;
      exp_t       e;
      logic [7:0] b;
      nbytes  = boot ? BOOT_N : USER_N;
      e.data  = boot ? 8'hA5 : 8'hC3;
      e.first = 1'b1;
      exp_q.push_back(e);
      e.first = 1'b0;
      e.data  = {4'h0, page[11:8]};
      sum     = int'(e.data);
      exp_q.push_back(e);
      e.data  = page[7:0];
      sum     = sum + int'(e.data);
      exp_q.push_back(e);
      for (int k = 0; k < nbytes; k++) begin
         for (int j = 0; j < 8; j++) b[j] = mem_m[8*k + j];
         e.data = b;
         sum    = sum + int'(b);
         exp_q.push_back(e);
      end
      e.data = 8'(sum % 256);
      exp_q.push_back(e);
   endfunction

   task automatic wr_bit(input int addr, input bit v);
      @(negedge clk);
      nwr     = 1'b0;
      wr_addr = 13'(addr);
      wr_data = v;
      mem_m[addr] = v;
   endtask

   task automatic wr_end();
      @(negedge clk);
      nwr = 1'b1;
   endtask

   task automatic send_pkt(input bit boot, input bit both, input logic [11:0] page, input bit intrude);
      int n;
      int frames;
      int exp_busy;
      push_packet(boot, page);
      frames   = (boot ? BOOT_N : USER_N) + 4;
      exp_busy = frames * 10 * CPB + (frames - 1) * 2;
      @(negedge clk);
      relpage = page;
      if (boot || both) nboot = 1'b0;
      if (!boot || both) nuser = 1'b0;
      @(negedge clk);
      nboot = 1'b1;
      nuser = 1'b1;
      n = 0;
      while (busy !== 1'b1 && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      check(busy === 1'b1, "busy_rise", longint'(busy), 1);
      relpage = 12'($urandom);
      n = 0;
      while (busy === 1'b1 && n < exp_busy + 100) begin
         n++;
         if (intrude) begin
            if (n == 10) begin
               nwr = 1'b0; wr_addr = 13'd5; wr_data = 1'b1;
            end
            if (n == 11) nwr = 1'b1;
            if (n == 30) nuser = 1'b0;
            if (n == 31) nuser = 1'b1;
         end
         @(posedge clk); #1;
      end
      check(n == exp_busy, "busy_len", longint'(n), longint'(exp_busy));
      repeat (6) @(posedge clk);
      #1;
      check(exp_q.size() == 0, "frames_left", longint'(exp_q.size()), 0);
   endtask

   // Monitor: decodes each frame, checks bit stability, framing, data and inter-frame gap.
   initial begin : monitor
      logic [9:0] fr;
      bit         stable;
      int         start_cyc;
      exp_t       e;
      forever begin
         @(posedge clk); #1;
         if (rst_n === 1'b1 && txd === 1'b0) begin
            start_cyc = cyc;
            stable    = 1'b1;
            fr        = '0;
            for (int b = 0; b < 10; b++) begin
               for (int c = 0; c < int'(CPB); c++) begin
                  if (b != 0 || c != 0) begin
                     @(posedge clk); #1;
                  end
                  if (c == 0) fr[b] = txd;
                  else if (txd !== fr[b]) stable = 1'b0;
               end
            end
            if (mon_en) begin
               check(stable, "bit_period", longint'(stable), 1);
               check(fr[0] == 1'b0 && fr[9] == 1'b1, "framing", longint'(fr),
                     longint'({1'b1, fr[8:1], 1'b0}));
               if (exp_q.size() == 0) begin
                  check(1'b0, "unexpected_frame", longint'(fr[8:1]), 0);
               end else begin
                  e = exp_q.pop_front();
                  check(fr[8:1] == e.data, "byte", longint'(fr[8:1]), longint'(e.data));
                  if (!e.first)
                     check(start_cyc - last_end - 1 == 2, "gap", longint'(start_cyc - last_end - 1), 2);
               end
            end
            last_end = cyc;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation timed out at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin : stim
      int  n;
      bit  quiet;
      repeat (3) @(negedge clk);
      check(txd === 1'b1, "rst_txd", longint'(txd), 1);
      check(busy === 1'b0, "rst_busy", longint'(busy), 0);
      check(overrun === 1'b0, "rst_overrun", longint'(overrun), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      mon_en = 1'b1;

      // User page with alternating bit pattern.
      for (int i = 0; i < 512; i++) wr_bit(i, i[0]);
      wr_end();
      send_pkt(1'b0, 1'b0, 12'h123, 1'b0);
      check(overrun === 1'b0, "user_overrun", longint'(overrun), 0);

      // Write and second request during BUSY are dropped and flagged.
      for (int i = 0; i < 16; i++) wr_bit(i, (i == 5) ? 1'b0 : 1'($urandom));
      wr_end();
      send_pkt(1'b0, 1'b0, 12'($urandom), 1'b1);
      check(overrun === 1'b1, "overrun_set", longint'(overrun), 1);
      repeat (60) @(posedge clk);
      #1;
      check(busy === 1'b0, "no_second_pkt", longint'(busy), 0);
      send_pkt(1'b0, 1'b0, 12'($urandom), 1'b0);

      // Asynchronous reset in the middle of a frame.
      mon_en = 1'b0;
      check(overrun === 1'b1, "overrun_sticky", longint'(overrun), 1);
      @(negedge clk);
      relpage = 12'h3C5;
      nuser   = 1'b0;
      @(negedge clk);
      nuser = 1'b1;
      n = 0;
      while (busy !== 1'b1 && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      check(busy === 1'b1, "rst_busy_rise", longint'(busy), 1);
      repeat (14) @(posedge clk);
      #1;
      check(txd === 1'b0, "pre_reset_txd", longint'(txd), 0);
      #2 rst_n = 1'b0;
      #1;
      check(txd === 1'b1, "async_rst_txd", longint'(txd), 1);
      check(busy === 1'b0, "async_rst_busy", longint'(busy), 0);
      check(overrun === 1'b0, "async_rst_overrun", longint'(overrun), 0);
      @(negedge clk);
      rst_n = 1'b1;
      quiet = 1'b1;
      repeat (60) begin
         @(posedge clk); #1;
         if (txd !== 1'b1 || busy !== 1'b0 || overrun !== 1'b0) quiet = 1'b0;
      end
      check(quiet, "post_reset_quiet", longint'(quiet), 1);
      mon_en = 1'b1;

      // Boot page, issued together with a user request: boot wins silently.
      for (int i = 0; i < int'(NBITS); i++) wr_bit(i, 1'b0);
      wr_bit(int'(NBITS) - 1, 1'b1);
      wr_end();
      send_pkt(1'b1, 1'b1, 12'h000, 1'b0);
      check(overrun === 1'b0, "simul_no_overrun", longint'(overrun), 0);

      // Randomized user pages.
      for (int r = 0; r < 6; r++) begin
         repeat (20) wr_bit(int'($urandom_range(0, 31)), 1'($urandom));
         wr_end();
         repeat ($urandom_range(0, 5)) @(negedge clk);
         send_pkt(1'b0, 1'b0, 12'($urandom), 1'b0);
      end
      check(overrun === 1'b0, "final_overrun", longint'(overrun), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
